uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, register map
// offsets, STATUS bit positions and the peripheral's address window.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Word offsets within the peripheral window
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    // STATUS register bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_COUNT_LSB = 8;

    // Address window decoded by the MMU into sel
    localparam logic [31:0] UART_BASE = 32'h0000_4000;
    localparam logic [31:0] UART_LAST = 32'h0000_400F;

    // Assemble the STATUS word; unlisted bits read as zero
    function automatic logic [31:0] status_word(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       overrun,
        input logic [7:0] count
    );
        logic [31:0] w;
        w                          = 32'd0;
        w[STAT_FULL]               = full;
        w[STAT_EMPTY]              = empty;
        w[STAT_BUSY]               = busy;
        w[STAT_OVERRUN]            = overrun;
        w[STAT_COUNT_LSB +: 8]     = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current occupancy and derive next count
    always_comb begin
        pop_ok_s  = pop & ~empty_r;
        push_ok_s = push & (~full_r | pop_ok_s);
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers (wrap naturally since DEPTH is a power of two) and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == CW'(0));
        end
    end

    // Storage array; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, STATUS register,
// sticky overrun flag and a half-empty interrupt.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BCW = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH+1);
    localparam logic [BCW-1:0] BAUD_RELOAD = BCW'(DIV - 1);

    tx_state_t        state_r;
    logic [BCW-1:0]   baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             irq_r;
    logic             overrun_r;

    logic [7:0]       fifo_dout_s;
    logic [CW-1:0]    fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    logic             wr_data_s;
    logic             wr_stat_s;
    logic             bit_end_s;
    logic             pop_s;
    logic             push_s;
    logic             overrun_set_s;
    logic [CW-1:0]    count_next_s;
    logic             busy_s;
    logic             unused_s;

    // Write strobes, FIFO handshakes and the occupancy after this edge
    always_comb begin
        wr_data_s     = sel & mem_write & (addr == ADDR_DATA);
        wr_stat_s     = sel & mem_write & (addr == ADDR_STATUS);
        bit_end_s     = (baud_cnt_r == BCW'(0));
        pop_s         = ~rst & ~fifo_empty_s &
                        ((state_r == TX_IDLE) | ((state_r == TX_STOP) & bit_end_s));
        push_s        = ~rst & wr_data_s & (~fifo_full_s | pop_s);
        overrun_set_s = wr_data_s & fifo_full_s & ~pop_s;
        if (push_s && !pop_s) begin
            count_next_s = fifo_count_s + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = fifo_count_s - CW'(1);
        end else begin
            count_next_s = fifo_count_s;
        end
        busy_s = (state_r != TX_IDLE) | ~fifo_empty_s;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wdata[7:0]),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // TX framing FSM; tx follows the state one cycle later so every bit
    // occupies exactly DIV cycles on the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= TX_IDLE;
            baud_cnt_r <= BCW'(0);
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r    <= fifo_dout_s;
                        baud_cnt_r <= BAUD_RELOAD;
                        state_r    <= TX_START;
                    end else begin
                        baud_cnt_r <= BCW'(0);
                    end
                end
                TX_START: begin
                    tx_r <= 1'b0;
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        bit_idx_r  <= 3'd0;
                        state_r    <= TX_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BCW'(1);
                    end
                end
                TX_DATA: begin
                    tx_r <= shift_r[0];
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= TX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BCW'(1);
                    end
                end
                TX_STOP: begin
                    tx_r <= 1'b1;
                    if (bit_end_s) begin
                        if (pop_s) begin
                            shift_r    <= fifo_dout_s;
                            baud_cnt_r <= BAUD_RELOAD;
                            state_r    <= TX_START;
                        end else begin
                            baud_cnt_r <= BCW'(0);
                            state_r    <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BCW'(1);
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag and half-empty interrupt tracking next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
            irq_r     <= 1'b1;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (wr_stat_s && wdata[STAT_OVERRUN]) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            irq_r <= (count_next_s <= CW'(FIFO_DEPTH / 2));
        end
    end

    // Read mux: only STATUS returns data, reads never change state
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_STATUS: rdata = status_word(fifo_full_s, fifo_empty_s, busy_s,
                                             overrun_r, 8'(fifo_count_s));
            default:     rdata = 32'd0;
        endcase
    end

    // Inputs with no function in this peripheral
    assign unused_s = ^{mem_read, wdata[31:8]};

    assign tx  = tx_r;
    assign irq = irq_r;

endmodule
